range_reader: RTL and testbench
===============================

Name: range_reader

Overview:
- Host-side sequencer for the range block. It launches a range run, waits for completion, then reads back all RAM_WORDS stored iteration counts.
- Read-back uses range's start/count address port (start[RAM_ADDR_BITS-1:0] selects a word; count is registered).
- Results go out as a valid/ready stream of (n, count) beats, and the block tracks the maximum count and its n.
- Sits between a bus-facing request register and one range instance.

Parameters:
- RAM_WORDS, 16, number of counts stored in range; must match the range instance.
- RAM_ADDR_BITS, 4, range RAM address width; must match the range instance.
- TIMEOUT_CYCLES, 1048576, maximum cycles to wait for rng_done before aborting.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  host requests a run starting at req_start.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_start  in  32  first n of the run.
- rng_go  out  1  to range go; one-cycle pulse.
- rng_start  out  32  to range start; first n at launch, word index during read-back.
- rng_done  in  1  from range done.
- rng_count  in  16  from range count.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts beat.
- out_n  out  32  n of this beat, base+idx modulo 2^32.
- out_count  out  16  iteration count for out_n.
- out_last  out  1  beat idx == RAM_WORDS-1.
- max_count  out  16  largest count seen in the current run.
- max_n  out  32  n giving max_count; earliest n wins ties.
- run_done  out  1  one-cycle pulse when the last beat is accepted.
- timeout  out  1  sticky error; cleared on next accepted request.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except req_ready=1. Internal idx, base and watchdog cleared.
- Accept (IDLE, req_valid=1):
  - Latch base=req_start.
  - Clear max_count, max_n, timeout.
  - Go to LAUNCH.
- LAUNCH (1 cycle): rng_go=1, rng_start=base → WAIT_DONE. rng_go is 0 in every other state.
- WAIT_DONE:
  - rng_start held at base.
  - rng_done is ignored in the first WAIT_DONE cycle (guards against a stale done from the previous run).
  - From cycle 2 on, rng_done=1 → ADDR with idx=0.
  - Watchdog counts cycles in WAIT_DONE. On reaching TIMEOUT_CYCLES: timeout=1, go to IDLE, no beats emitted.
- ADDR (1 cycle): rng_start = idx zero-extended to 32 bits → SETTLE.
- SETTLE (1 cycle): rng_start held → CAPTURE. Total read latency allowance is 2 cycles because range registers count.
- CAPTURE (1 cycle):
  - Load out_count=rng_count, out_n=base+idx, out_last=(idx==RAM_WORDS-1).
  - If rng_count > max_count (strictly greater), update max_count and max_n.
  - Go to EMIT.
- EMIT:
  - out_valid=1. out_n, out_count and out_last are held stable until out_ready=1.
  - On accept, out_valid drops the next cycle.
  - If out_last: run_done pulses 1 cycle, go to IDLE.
  - Otherwise idx+1 → ADDR.
- Throughput: at most one beat per 4 cycles. A back-to-back out_ready has no other effect.
- req_valid outside IDLE is ignored (req_ready=0); no queuing.
- max_count and max_n stay valid after run_done until the next accepted request.
- out_n arithmetic wraps at 32 bits: base=0xFFFFFFFF, idx=1 gives out_n=0.
- If rng_done drops during ADDR through EMIT, it is ignored; read-back continues.
- Reset mid-run aborts immediately with no run_done. The range instance has no reset; the next request relaunches it.

Test Plan:
- Basic run. Setup: bench range model with standard Collatz step counts. Stimulus: req_start=1. Response:
  - 16 beats, n=1..16, counts 0,1,7,2,5,8,16,3,19,6,14,9,9,17,17,4.
  - out_last only on n=16; run_done one pulse.
  - max_count=19, max_n=9.
- Backpressure: out_ready low 5 cycles during beat n=3. Response: out_valid, out_n=3 and out_count=7 held constant; no beat lost or duplicated; max unaffected.
- Tie: model returns count 17 for both idx 13 and 14, all others lower. Response: max_count=17, max_n=base+13.
- Stale done and timeout:
  - rng_done already 1 at launch, model drops it after go and never raises it; TIMEOUT_CYCLES=64.
  - Response: no beats, timeout=1 after 64 WAIT_DONE cycles, req_ready=1.
  - Next accepted request clears timeout.
- Wrap: req_start=0xFFFFFFF8. Response: out_n runs 0xFFFFFFF8..0xFFFFFFFF, then 0..7; rng_start during read-back is 0..15.
- Reset mid-run: assert reset during beat idx=5 EMIT. Response: out_valid=0 immediately, req_ready=1, no run_done; a fresh request then completes normally.

Source files
------------

// File: rtl/range_reader.sv
// range_reader: launches a range run, waits for done, then streams
// every stored count back as (n, count) beats and tracks the maximum.
module range_reader #(
    parameter int RAM_WORDS      = 16,
    parameter int RAM_ADDR_BITS  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_start,
    output logic        rng_go,
    output logic [31:0] rng_start,
    input  logic        rng_done,
    input  logic [15:0] rng_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_n,
    output logic [15:0] out_count,
    output logic        out_last,
    output logic [15:0] max_count,
    output logic [31:0] max_n,
    output logic        run_done,
    output logic        timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADDR,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [31:0]              base;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic [WD_W-1:0]          wd;
    logic [31:0]              idx_ext;
    logic                     accept;
    logic                     done_seen;
    logic                     wd_expired;
    logic                     idx_last;

    assign idx_ext    = {{(32-RAM_ADDR_BITS){1'b0}}, idx};
    assign accept     = (state == S_IDLE) && req_valid;
    // wd is zero only in the first WAIT cycle, where a stale done is ignored
    assign done_seen  = (wd != '0) && rng_done;
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
    assign idx_last   = (idx == RAM_ADDR_BITS'(RAM_WORDS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (req_valid) state_nx = S_LAUNCH;
            S_LAUNCH:  state_nx = S_WAIT;
            S_WAIT: begin
                if (done_seen)       state_nx = S_ADDR;
                else if (wd_expired) state_nx = S_IDLE;
            end
            S_ADDR:    state_nx = S_SETTLE;
            S_SETTLE:  state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_EMIT;
            S_EMIT: begin
                if (out_ready) state_nx = out_last ? S_IDLE : S_ADDR;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    // Datapath: base, read index, watchdog, beat registers and maximum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= '0;
            idx       <= '0;
            wd        <= '0;
            out_n     <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            max_count <= '0;
            max_n     <= '0;
            timeout   <= 1'b0;
        end else begin
            if (accept) begin
                base      <= req_start;
                max_count <= '0;
                max_n     <= '0;
                timeout   <= 1'b0;
            end
            if (state == S_WAIT) begin
                wd <= wd + WD_W'(1);
                if (done_seen)       idx     <= '0;
                else if (wd_expired) timeout <= 1'b1;
            end else begin
                wd <= '0;
            end
            if (state == S_CAPTURE) begin
                out_count <= rng_count;
                out_n     <= base + idx_ext;
                out_last  <= idx_last;
                if (rng_count > max_count) begin
                    max_count <= rng_count;
                    max_n     <= base + idx_ext;
                end
            end
            if (state == S_EMIT && out_ready && !out_last)
                idx <= idx + RAM_ADDR_BITS'(1);
        end
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = (state == S_IDLE);
        rng_go    = (state == S_LAUNCH);
        out_valid = (state == S_EMIT);
        run_done  = (state == S_EMIT) && out_ready && out_last;
        unique case (state)
            S_IDLE:           rng_start = '0;
            S_LAUNCH, S_WAIT: rng_start = base;
            default:          rng_start = idx_ext;
        endcase
    end

endmodule

// File: tb/tb_range_reader.sv
// tb_range_reader: randomized scoreboard bench for range_reader with
// a behavioural range model (RAM of counts, registered count, done).
module tb_range_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_start;
    logic        rng_go;
    logic [31:0] rng_start;
    logic        rng_done = 1'b0;
    logic [15:0] rng_count = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;
    logic [15:0] max_count;
    logic [31:0] max_n;
    logic        run_done;
    logic        timeout;

    range_reader #(
        .RAM_WORDS(16),
        .RAM_ADDR_BITS(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_start(req_start),
        .rng_go(rng_go),
        .rng_start(rng_start),
        .rng_done(rng_done),
        .rng_count(rng_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_n(out_n),
        .out_count(out_count),
        .out_last(out_last),
        .max_count(max_count),
        .max_n(max_n),
        .run_done(run_done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        logic [15:0] c;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          fails = 0;
    int          rd_pulses = 0;
    int          cyc = 0;
    int          last_acc = -100;
    logic [31:0] cur_base = '0;
    logic [15:0] exp_max = '0;
    logic [31:0] exp_max_n = '0;

    // range model state
    logic [15:0] ram[16];
    int          done_delay = 3;
    int          dcnt = 0;
    logic        go_d = 1'b0;

    // consumer control
    bit          rand_ready = 0;
    logic [31:0] stall_n = '0;
    int          stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // range model: registered count lookup, done drops the cycle after
    // go is seen and rises again after done_delay cycles (0 = never)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rng_count <= (rng_start < 32'd16) ? ram[rng_start[3:0]] : 16'hDEAD;
        go_d <= rng_go;
        if (go_d) begin
            rng_done <= 1'b0;
            dcnt     <= done_delay;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) rng_done <= 1'b1;
        end
    end

    // consumer: optional random ready, optional stall on one beat
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && out_n == stall_n && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // monitor: pops the scoreboard on every accepted beat
    logic        hold_pend = 1'b0;
    logic [48:0] held = '0;
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
            last_acc  = -100;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({out_n, out_count, out_last}),
                    64'(held));
            end
            hold_pend = out_valid && !out_ready;
            held      = {out_n, out_count, out_last};
            if (out_valid && out_ready) begin
                chk("beat_gap_ge4", 64'(cyc - last_acc >= 4), 64'd1);
                last_acc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(out_n), 64'hFFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_n", 64'(out_n), 64'(e.n));
                    chk("beat_count", 64'(out_count), 64'(e.c));
                    chk("beat_last", 64'(out_last), 64'(e.last));
                end
            end
            if (run_done) begin
                rd_pulses++;
                chk("run_done_on_last",
                    64'(out_valid && out_ready && out_last), 64'd1);
            end
            if (rng_go) chk("go_start", 64'(rng_start), 64'(cur_base));
        end
    end

    function automatic logic [15:0] csteps(input logic [31:0] n0);
        longint unsigned n;
        int s;
        n = 64'(n0);
        s = 0;
        while (n > 1 && s < 2000) begin
            n = n[0] ? 3 * n + 1 : n / 2;
            s++;
        end
        return 16'(s);
    endfunction

    task automatic fill_collatz(input logic [31:0] b);
        for (int i = 0; i < 16; i++) ram[i] = csteps(b + 32'(i));
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) ram[i] = 16'($urandom);
    endtask

    // reference: one beat per stored word, max strictly greater wins
    task automatic push_expected(input logic [31:0] b);
        beat_t e;
        exp_max   = '0;
        exp_max_n = '0;
        for (int i = 0; i < 16; i++) begin
            e.n    = b + 32'(i);
            e.c    = ram[i];
            e.last = (i == 15);
            sb.push_back(e);
            if (ram[i] > exp_max) begin
                exp_max   = ram[i];
                exp_max_n = b + 32'(i);
            end
        end
    endtask

    task automatic start_req(input logic [31:0] b);
        int k;
        k = 0;
        while (!req_ready && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
        rd_pulses = 0;
        cur_base  = b;
        req_start = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_run_end();
        int k;
        k = 0;
        while (!req_ready && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("run_end_in_time", 64'(req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("run_done_pulses", 64'(rd_pulses), 64'd1);
        chk("max_count", 64'(max_count), 64'(exp_max));
        chk("max_n", 64'(max_n), 64'(exp_max_n));
        chk("timeout_clear", 64'(timeout), 64'd0);
    endtask

    task automatic full_run(input logic [31:0] b, input bit poke);
        push_expected(b);
        start_req(b);
        if (poke) begin
            repeat (10) @(posedge clk);
            #1;
            if (!req_ready) begin
                req_start = 32'($urandom);
                req_valid = 1'b1;
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        wait_run_end();
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] b;
        int k;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_start = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rng_go", 64'(rng_go), 64'd0);
        chk("rst_rng_start", 64'(rng_start), 64'd0);
        chk("rst_out_n", 64'(out_n), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_max", 64'({max_count, max_n}), 64'd0);
        chk("rst_run_done", 64'(run_done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // basic Collatz run with a 5-cycle stall on n=3
        done_delay = 5;
        fill_collatz(32'd1);
        stall_n    = 32'd3;
        stall_left = 5;
        full_run(32'd1, 0);
        chk("basic_max_19", 64'(max_count), 64'd19);
        chk("basic_max_n_9", 64'(max_n), 64'd9);

        // stale done at launch, done never returns: watchdog fires
        done_delay = 0;
        push_expected(32'h1234_0000);
        sb.delete();
        start_req(32'h1234_0000);
        k = 0;
        while (!timeout && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("timeout_cycles", 64'(k), 64'd65);
        chk("timeout_set", 64'(timeout), 64'd1);
        chk("timeout_req_ready", 64'(req_ready), 64'd1);
        chk("timeout_max", 64'(max_count), 64'd0);
        chk("timeout_rd", 64'(rd_pulses), 64'd0);

        // next request clears timeout and completes
        done_delay = 3;
        fill_rand();
        b = 32'($urandom);
        push_expected(b);
        start_req(b);
        chk("timeout_cleared", 64'(timeout), 64'd0);
        wait_run_end();

        // tie on 17 at idx 13 and 14: earliest wins
        for (int i = 0; i < 16; i++) ram[i] = 16'($urandom_range(0, 16));
        ram[13] = 16'd17;
        ram[14] = 16'd17;
        b = 32'($urandom);
        full_run(b, 0);
        chk("tie_max_n", 64'(max_n), 64'(b + 32'd13));

        // wrap across 2^32
        fill_rand();
        rand_ready = 1;
        full_run(32'hFFFF_FFF8, 0);

        // randomized runs, one with a request poked mid-run
        for (int r = 0; r < 4; r++) begin
            done_delay = $urandom_range(1, 20);
            fill_rand();
            full_run(32'($urandom), r == 1);
        end

        // reset during EMIT of idx 5
        rand_ready = 0;
        done_delay = 4;
        fill_rand();
        b = 32'($urandom);
        push_expected(b);
        stall_n    = b + 32'd5;
        stall_left = 3;
        start_req(b);
        k = 0;
        while (!(out_valid && out_n == b + 32'd5) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mid_reach_idx5", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd1);
        chk("mid_run_done", 64'(run_done), 64'd0);
        chk("mid_rd_pulses", 64'(rd_pulses), 64'd0);
        sb.delete();
        stall_left = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_max_clear", 64'(max_count), 64'd0);
        @(posedge clk);
        #1;
        fill_rand();
        full_run(32'($urandom), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
